// File: rtl/rd_fwft_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rd_fwft_stage_pkg
// Brief    : Shared constants, types and helpers for the FWFT read port.
// Revision : 1.0 - initial release
// ============================================================================
package rd_fwft_stage_pkg;

    localparam int c_BUF_DEPTH = 2;
    localparam int c_CNT_W     = $clog2(c_BUF_DEPTH + 1);

    typedef logic [c_CNT_W-1:0] cnt_t;

    localparam cnt_t               c_CNT_FULL = cnt_t'(c_BUF_DEPTH);
    localparam logic [c_CNT_W:0]   c_SUM_FULL = (c_CNT_W + 1)'(c_BUF_DEPTH);

    // Buffered words plus the one possibly still in flight from the RAM.
    function automatic logic has_room(input cnt_t count, input logic issued);
        logic [c_CNT_W:0] sum;
        sum = {1'b0, count} + {{c_CNT_W{1'b0}}, issued};
        return sum < c_SUM_FULL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : rd_out_buf
// Brief    : Two-entry register FIFO presenting a registered head word.
// Revision : 1.0 - initial release
// ============================================================================
module rd_out_buf
    import rd_fwft_stage_pkg::*;
#(
    parameter int P_DATA_MSB = 31
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [P_DATA_MSB:0] i_data,
    input  logic              i_pop,
    output logic [P_DATA_MSB:0] o_data,
    output logic              o_valid,
    output cnt_t              o_count
);

    logic [P_DATA_MSB:0] r_mem [c_BUF_DEPTH];
    logic                r_wr_idx;
    logic                r_rd_idx;
    cnt_t                r_count;
    logic                w_pop;

    assign w_pop = i_pop & (r_count != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < c_BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_idx] <= i_data;
                r_wr_idx        <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_idx];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

`ifndef SYNTHESIS
    // The issue throttle upstream must never let a word arrive with no free slot.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(i_push && !w_pop && r_count == c_CNT_FULL));
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/rd_fwft_stage.sv
`default_nettype none
// ============================================================================
// Module   : rd_fwft_stage
// Brief    : First-word-fall-through read port: issue, accept detect, output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module rd_fwft_stage
    import rd_fwft_stage_pkg::*;
#(
    parameter int P_PTR_MSB  = 4,
    parameter int P_DATA_MSB = 31
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_empty,
    input  logic [P_PTR_MSB:0]   i_rd_ptr,
    output logic                 o_inc,
    output logic                 o_ram_en,
    output logic [P_PTR_MSB-1:0] o_ram_addr,
    input  logic [P_DATA_MSB:0]  i_ram_data,
    output logic [P_DATA_MSB:0]  o_data,
    output logic                 o_valid,
    input  logic                 i_ready
);

    logic               r_issued;
    logic [P_PTR_MSB:0] r_prev_ptr;
    logic               w_accept;
    logic               w_pop;
    cnt_t               w_count;

    assign w_pop = o_valid & i_ready;

    // The controller may drop an increment on a stale empty; only a pointer move proves it landed.
    assign w_accept = r_issued & (i_rd_ptr != r_prev_ptr);

    assign o_inc      = i_rst_n & ~i_empty & (has_room(w_count, r_issued) | w_pop);
    assign o_ram_en   = o_inc;
    assign o_ram_addr = i_rd_ptr[P_PTR_MSB-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_issued   <= 1'b0;
            r_prev_ptr <= '0;
        end else begin
            r_issued   <= o_inc;
            r_prev_ptr <= i_rd_ptr;
        end
    end

    rd_out_buf #(
        .P_DATA_MSB (P_DATA_MSB)
    ) u_out_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_accept),
        .i_data  (i_ram_data),
        .i_pop   (w_pop),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_count (w_count)
    );

endmodule
`default_nettype wire
